// File: rtl/rr_arbiter.sv
// rr_arbiter: registered N-way request arbiter with round-robin or fixed
// priority selection, a grant/ack handshake and a rotating priority pointer.
// Optional grant timeout is compiled in when RR_ARBITER_TIMEOUT_EN is defined;
// without it the timeout output is tied low and grants hold until ack.
module rr_arbiter #(
  parameter int N       = 4,
  parameter bit MSB     = 1'b1,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 rr_en,
  input  logic                 ack,
  output logic [N-1:0]         gnt,
  output logic                 gnt_vld,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 timeout
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST    = IW'(N - 1);
  localparam logic [IW-1:0] PTR_RST = MSB ? LAST : '0;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   ptr_q, ptr_d;

  // Candidate slot gi holds the requester index searched in position gi, so
  // slot 0 is the highest priority and the winner is the lowest set slot.
  logic [IW-1:0]   cand_idx [N];
  logic [N-1:0]    cand_req;
  logic [N-1:0]    win_oh;
  logic [IW-1:0]   win_idx;
  logic            win_found;
  logic            expire;
  logic            arb;

  if (N < 2 || TIMEOUT < 2) begin : g_bad_params
    $error("rr_arbiter: N and TIMEOUT must both be at least 2");
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    localparam logic [IW-1:0] FIX_IDX = MSB ? IW'(N - 1 - gi) : IW'(gi);
    logic [IW-1:0] rr_idx;
    if (MSB) begin : g_down
      // ptr, ptr-1, ... wrapping from 0 back to N-1
      assign rr_idx = (ptr_q >= IW'(gi)) ? ptr_q - IW'(gi) : ptr_q + IW'(N - gi);
    end else begin : g_up
      // ptr, ptr+1, ... wrapping from N-1 back to 0
      assign rr_idx = (ptr_q >= IW'(N - gi)) ? ptr_q - IW'(N - gi) : ptr_q + IW'(gi);
    end
    assign cand_idx[gi] = rr_en ? rr_idx : FIX_IDX;
    assign cand_req[gi] = req[cand_idx[gi]];
    assign win_oh[gi]   = win_found && (win_idx == IW'(gi));
  end

  // Priority pick: the first set candidate slot wins.
  always_comb begin
    win_found = |cand_req;
    win_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand_req[i]) win_idx = cand_idx[i];
    end
  end

  // An arbitration happens whenever the resource is free or being released.
  assign arb = (state_q == S_IDLE) || ack || expire;

`ifdef RR_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q;

  // Grant is revoked after TIMEOUT cycles of holding without ack; ack wins a tie.
  assign expire = (state_q == S_GRANT) && !ack && (cnt_q == CW'(TIMEOUT - 1));

  // Hold counter restarts on every arbitration and counts cycles held.
  always_comb begin
    cnt_d = cnt_q;
    if (arb)                      cnt_d = '0;
    else if (state_q == S_GRANT)  cnt_d = cnt_q + 1'b1;
  end

  // Hold counter and timeout pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= expire;
    end
  end

  assign timeout = timeout_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  // State, grant and pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= PTR_RST;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: re-arbitrate when free or released, otherwise hold.
  always_comb begin
    state_d = state_q;
    if (arb) state_d = win_found ? S_GRANT : S_IDLE;
  end

  // Next grant and pointer; pointer moves past the winner only in round robin.
  always_comb begin
    gnt_d = gnt_q;
    idx_d = idx_q;
    ptr_d = ptr_q;
    if (arb) begin
      if (win_found) begin
        gnt_d = win_oh;
        idx_d = win_idx;
        if (rr_en) begin
          if (MSB) ptr_d = (win_idx == '0) ? LAST : win_idx - 1'b1;
          else     ptr_d = (win_idx == LAST) ? '0 : win_idx + 1'b1;
        end
      end else begin
        gnt_d = '0;
        idx_d = '0;
      end
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = (state_q == S_GRANT);
  assign gnt_idx = idx_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: two arbiters (ascending and descending search) driven with
// shared stimulus; directed scenarios plus randomized traffic checked against
// a behavioural model. Timeout scenarios follow RR_ARBITER_TIMEOUT_EN.
module tb_rr_arbiter;

  localparam int TO = 4;
`ifdef RR_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rr_en = 1'b1;
  logic       ack = 1'b0;
  logic [3:0] req = 4'b0;
  logic [3:0] g0, g1;
  logic       v0, v1, t0, t1;
  logic [1:0] i0, i1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_arbiter #(.N(4), .MSB(1'b0), .TIMEOUT(TO)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en), .ack(ack),
    .gnt(g0), .gnt_vld(v0), .gnt_idx(i0), .timeout(t0)
  );

  rr_arbiter #(.N(4), .MSB(1'b1), .TIMEOUT(TO)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en), .ack(ack),
    .gnt(g1), .gnt_vld(v1), .gnt_idx(i1), .timeout(t1)
  );

  // Behavioural model; index 0 models ascending search, index 1 descending.
  int m_ptr  [2];
  bit m_held [2];
  int m_idx  [2];
  int m_cnt  [2];
  bit m_to   [2];

  function automatic int pick(int msb, logic [3:0] r, logic rr, int ptr);
    int order [4];
    for (int i = 0; i < 4; i++) begin
      if (rr) order[i] = msb ? (ptr + 4 - i) % 4 : (ptr + i) % 4;
      else    order[i] = msb ? 3 - i : i;
    end
    foreach (order[i]) if (r[order[i]]) return order[i];
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        m_held[m] = 1'b0; m_idx[m] = 0; m_cnt[m] = 0; m_to[m] = 1'b0;
        m_ptr[m]  = (m == 1) ? 3 : 0;
      end else begin
        bit exp_now;
        int w;
        exp_now = TO_EN && m_held[m] && !ack && (m_cnt[m] == TO - 1);
        m_to[m] = exp_now;
        if (!m_held[m] || ack || exp_now) begin
          w = pick(m, req, rr_en, m_ptr[m]);
          m_cnt[m] = 0;
          if (w >= 0) begin
            m_held[m] = 1'b1;
            m_idx[m]  = w;
            if (rr_en) m_ptr[m] = (m == 1) ? (w + 3) % 4 : (w + 1) % 4;
          end else begin
            m_held[m] = 1'b0;
            m_idx[m]  = 0;
          end
        end else begin
          m_cnt[m]++;
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 4'b0; ack = 1'b0; rr_en = 1'b1;
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; ack = 1'b1; rr_en = 1'b1;
    repeat (3) cyc();
    checks++; if (g0 !== 4'b0) begin errors++; $display("FAIL reset_gnt0: got %b want 0000", g0); end
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL reset_vld0: got %b want 0", v0); end
    checks++; if (i0 !== 2'd0) begin errors++; $display("FAIL reset_idx0: got %0d want 0", i0); end
    checks++; if (t0 !== 1'b0) begin errors++; $display("FAIL reset_to0: got %b want 0", t0); end
    checks++; if (g1 !== 4'b0 || v1 !== 1'b0 || i1 !== 2'd0 || t1 !== 1'b0) begin
      errors++; $display("FAIL reset_dut1: got gnt=%b vld=%b idx=%0d to=%b want all 0", g1, v1, i1, t1);
    end
    rst_n = 1'b1; ack = 1'b0;
    cyc();
    $display("txn reset_release req=%b gnt0=%b gnt1=%b", req, g0, g1);
    checks++; if (g0 !== 4'b0001) begin errors++; $display("FAIL first_gnt0: got %b want 0001", g0); end
    checks++; if (g1 !== 4'b1000) begin errors++; $display("FAIL first_gnt1: got %b want 1000", g1); end
  endtask

  task automatic test_round_robin();
    int exp0 [5] = '{0, 1, 2, 3, 0};
    int exp1 [5] = '{3, 2, 1, 0, 3};
    do_reset();
    req = 4'b1111; ack = 1'b1; rr_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      $display("txn rr step=%0d idx0=%0d idx1=%0d", k, i0, i1);
      checks++; if (v0 !== 1'b1 || i0 !== exp0[k][1:0]) begin
        errors++; $display("FAIL rr_up[%0d]: got vld=%b idx=%0d want vld=1 idx=%0d", k, v0, i0, exp0[k]);
      end
      checks++; if (v1 !== 1'b1 || i1 !== exp1[k][1:0]) begin
        errors++; $display("FAIL rr_down[%0d]: got vld=%b idx=%0d want vld=1 idx=%0d", k, v1, i1, exp1[k]);
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_fixed_priority();
    do_reset();
    rr_en = 1'b0; req = 4'b1010; ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      $display("txn fixed step=%0d gnt0=%b gnt1=%b", k, g0, g1);
      checks++; if (g0 !== 4'b0010) begin errors++; $display("FAIL fixed_gnt0[%0d]: got %b want 0010", k, g0); end
      checks++; if (g1 !== 4'b1000) begin errors++; $display("FAIL fixed_gnt1[%0d]: got %b want 1000", k, g1); end
      ack = 1'b1;
      cyc();
      ack = 1'b0;
    end
    // Pointer must still be at its reset value when switching to round robin.
    ack = 1'b1; rr_en = 1'b1; req = 4'b1111;
    cyc();
    checks++; if (i0 !== 2'd0) begin errors++; $display("FAIL fixed_ptr0: got idx %0d want 0", i0); end
    checks++; if (i1 !== 2'd3) begin errors++; $display("FAIL fixed_ptr1: got idx %0d want 3", i1); end
    ack = 1'b0;
  endtask

  task automatic test_hold_reset();
    do_reset();
    rr_en = 1'b1; req = 4'b0100; ack = 1'b0;
    cyc();
    req = 4'b0000;
    checks++; if (g0 !== 4'b0100 || g1 !== 4'b0100) begin
      errors++; $display("FAIL hold_grant: got %b/%b want 0100", g0, g1);
    end
    for (int k = 0; k < 5; k++) begin
      cyc();
      checks++; if (g0 !== 4'b0100 || v0 !== 1'b1 || i0 !== 2'd2) begin
        errors++; $display("FAIL hold_keep[%0d]: got gnt=%b vld=%b idx=%0d want 0100/1/2", k, g0, v0, i0);
      end
    end
    rst_n = 1'b0;
    cyc();
    $display("txn mid_grant_reset gnt0=%b gnt1=%b", g0, g1);
    checks++; if (g0 !== 4'b0 || v0 !== 1'b0 || i0 !== 2'd0 || g1 !== 4'b0) begin
      errors++; $display("FAIL hold_reset: got gnt0=%b vld0=%b idx0=%0d gnt1=%b want zeros", g0, v0, i0, g1);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_timeout();
`ifdef RR_ARBITER_TIMEOUT_EN
    do_reset();
    req = 4'b0100; ack = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      req = 4'b0000;
      checks++; if (g0 !== 4'b0100 || t0 !== 1'b0) begin
        errors++; $display("FAIL to_hold[%0d]: got gnt=%b to=%b want 0100/0", k, g0, t0);
      end
    end
    cyc();
    $display("txn timeout gnt0=%b to0=%b", g0, t0);
    checks++; if (g0 !== 4'b0 || t0 !== 1'b1 || t1 !== 1'b1) begin
      errors++; $display("FAIL to_expire: got gnt=%b to0=%b to1=%b want 0000/1/1", g0, t0, t1);
    end
    cyc();
    checks++; if (t0 !== 1'b0) begin errors++; $display("FAIL to_pulse: got %b want 0", t0); end
    do_reset();
    req = 4'b0100; ack = 1'b0;
    cyc();
    req = 4'b0000;
    repeat (3) cyc();
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    checks++; if (g0 !== 4'b0 || t0 !== 1'b0) begin
      errors++; $display("FAIL to_ack_wins: got gnt=%b to=%b want 0000/0", g0, t0);
    end
    cyc();
    checks++; if (t0 !== 1'b0) begin errors++; $display("FAIL to_ack_after: got %b want 0", t0); end
`else
    do_reset();
    req = 4'b0100; ack = 1'b0;
    cyc();
    req = 4'b0000;
    for (int k = 0; k < 20; k++) begin
      cyc();
      checks++; if (g0 !== 4'b0100 || t0 !== 1'b0) begin
        errors++; $display("FAIL no_to_hold[%0d]: got gnt=%b to=%b want 0100/0", k, g0, t0);
      end
    end
    $display("txn no_timeout gnt0=%b after 20 cycles", g0);
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      req   = 4'($urandom_range(0, 15));
      ack   = ($urandom_range(0, 2) == 0);
      rr_en = ($urandom_range(0, 3) != 0);
      cyc();
      $display("txn rand %0d rst_n=%b req=%b ack=%b rr=%b gnt0=%b gnt1=%b to=%b%b",
               n, rst_n, req, ack, rr_en, g0, g1, t0, t1);
      for (int m = 0; m < 2; m++) begin
        logic [3:0] ag, eg;
        logic       av, at;
        logic [1:0] ai, ei;
        ag = (m == 0) ? g0 : g1;
        av = (m == 0) ? v0 : v1;
        ai = (m == 0) ? i0 : i1;
        at = (m == 0) ? t0 : t1;
        eg = m_held[m] ? (4'b0001 << m_idx[m]) : 4'b0000;
        ei = m_idx[m][1:0];
        checks++;
        if (ag !== eg || av !== m_held[m] || ai !== ei || at !== m_to[m]) begin
          errors++;
          $display("FAIL rand[%0d] dut%0d: got gnt=%b vld=%b idx=%0d to=%b want gnt=%b vld=%b idx=%0d to=%b",
                   n, m, ag, av, ai, at, eg, m_held[m], ei, m_to[m]);
        end
      end
    end
    rst_n = 1'b1; ack = 1'b0; req = 4'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_hold_reset();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
